// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode width and encodings used by the issue queue and the ALU.
package alu_pkg;

    localparam int OP_W = 2;

    localparam logic [OP_W-1:0] OP_ADD = 2'b00;
    localparam logic [OP_W-1:0] OP_OR  = 2'b01;
    localparam logic [OP_W-1:0] OP_SUB = 2'b10;
    localparam logic [OP_W-1:0] OP_XOR = 2'b11;

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with flush, occupancy count and an asynchronously read head.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/alu_op_queue.sv
// Operation-issue queue feeding the combinational ALU; tags each accepted op with a wrapping sequence number.
module alu_op_queue
    import alu_pkg::*;
#(
    parameter int N     = 4,
    parameter int DEPTH = 4,
    parameter int SEQ_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N-1:0]           in_a,
    input  logic [N-1:0]           in_b,
    input  logic [OP_W-1:0]        in_opcode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N-1:0]           out_a,
    output logic [N-1:0]           out_b,
    output logic [OP_W-1:0]        out_opcode,
    output logic [SEQ_W-1:0]       out_seq,
    output logic [$clog2(DEPTH):0] count
);

    typedef struct packed {
        logic [N-1:0]     a;
        logic [N-1:0]     b;
        logic [OP_W-1:0]  opcode;
        logic [SEQ_W-1:0] seq;
    } alu_op_t;

    localparam int WIDTH = $bits(alu_op_t);

    alu_op_t          wr_entry, head;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic             fifo_full, fifo_empty;
    logic             push, pop;

    assign in_ready  = ~fifo_full;
    assign out_valid = ~fifo_empty;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign wr_entry = '{a: in_a, b: in_b, opcode: in_opcode, seq: seq_q};

    // A push dropped by flush must not consume a tag.
    always_comb begin
        seq_d = seq_q;
        if (push && !flush) seq_d = seq_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) seq_q <= '0;
        else     seq_q <= seq_d;
    end

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_entry),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (count)
    );

    // Empty queue presents an add of 0+0 to the ALU.
    assign out_a      = out_valid ? head.a      : '0;
    assign out_b      = out_valid ? head.b      : '0;
    assign out_opcode = out_valid ? head.opcode : '0;
    assign out_seq    = out_valid ? head.seq    : '0;

endmodule

// File: tb/tb_alu_op_queue.sv
// Self-checking bench for alu_op_queue: directed vector table, hand-written corner sequences, random traffic.
module tb_alu_op_queue;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_a = '0;
    logic [3:0] in_b = '0;
    logic [1:0] in_opcode = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_a;
    logic [3:0] out_b;
    logic [1:0] out_opcode;
    logic [7:0] out_seq;
    logic [2:0] count;

    always #5 clk = ~clk;

    alu_op_queue #(.N(4), .DEPTH(4), .SEQ_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_opcode  (in_opcode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_a      (out_a),
        .out_b      (out_b),
        .out_opcode (out_opcode),
        .out_seq    (out_seq),
        .count      (count)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] op;
        logic [7:0] seq;
    } op_t;

    typedef struct {
        int rst, flush, iv, ordy, a, b, op;
        int e_cnt, e_valid, e_rdy, e_a, e_b, e_op, e_seq;
    } vec_t;

    op_t        mq[$];
    logic [7:0] mseq = '0;
    int         n_checks = 0;
    int         n_fail = 0;
    vec_t       vt[18];

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        int n;
        op_t h;
        n = mq.size();
        h = '{a: 4'd0, b: 4'd0, op: 2'd0, seq: 8'd0};
        if (n != 0) h = mq[0];
        chk({tag, ".count"},     int'(count),      n);
        chk({tag, ".out_valid"}, int'(out_valid),  int'(n != 0));
        chk({tag, ".in_ready"},  int'(in_ready),   int'(n != 4));
        chk({tag, ".out_a"},     int'(out_a),      int'(h.a));
        chk({tag, ".out_b"},     int'(out_b),      int'(h.b));
        chk({tag, ".out_op"},    int'(out_opcode), int'(h.op));
        chk({tag, ".out_seq"},   int'(out_seq),    int'(h.seq));
    endtask

    // One clock: drive inputs, advance the reference queue by the spec rules, check after the edge.
    task automatic step(input logic r, input logic f, input logic iv, input logic ordy,
                        input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                        input string tag);
        bit m_push, m_pop;
        rst = r; flush = f; in_valid = iv; out_ready = ordy;
        in_a = a; in_b = b; in_opcode = op;
        m_push = iv && (mq.size() != 4);
        m_pop  = ordy && (mq.size() != 0);
        @(posedge clk);
        if (r) begin
            mq.delete();
            mseq = '0;
        end else if (f) begin
            mq.delete();
        end else begin
            if (m_pop) void'(mq.pop_front());
            if (m_push) begin
                mq.push_back('{a: a, b: b, op: op, seq: mseq});
                mseq = mseq + 8'd1;
            end
        end
        #1;
        $display("[%0t] %s rst=%0b fl=%0b iv=%0b or=%0b in=%0h/%0h/%0h -> cnt=%0d v=%0b rdy=%0b out=%0h/%0h/%0h seq=%0d",
                 $time, tag, r, f, iv, ordy, a, b, op, count, out_valid, in_ready,
                 out_a, out_b, out_opcode, out_seq);
        check_model(tag);
    endtask

    initial begin
        int last;
        bit wrapped;

        vt = '{
            '{1,0,0,0, 0,0,0,  0,0,1, 0,0,0,0},
            '{0,0,0,0, 0,0,0,  0,0,1, 0,0,0,0},
            '{0,0,1,0, 3,2,0,  1,1,1, 3,2,0,0},
            '{0,0,0,0, 0,0,0,  1,1,1, 3,2,0,0},
            '{0,0,0,0, 0,0,0,  1,1,1, 3,2,0,0},
            '{0,0,0,0, 0,0,0,  1,1,1, 3,2,0,0},
            '{0,0,0,0, 0,0,0,  1,1,1, 3,2,0,0},
            '{0,0,0,0, 0,0,0,  1,1,1, 3,2,0,0},
            '{0,0,1,0, 1,5,1,  2,1,1, 3,2,0,0},
            '{0,0,1,0, 7,7,2,  3,1,1, 3,2,0,0},
            '{0,0,1,0, 15,1,3, 4,1,0, 3,2,0,0},
            '{0,0,1,0, 9,9,0,  4,1,0, 3,2,0,0},
            '{0,0,1,1, 9,9,0,  3,1,1, 1,5,1,1},
            '{0,0,1,0, 9,9,0,  4,1,0, 1,5,1,1},
            '{0,0,0,1, 0,0,0,  3,1,1, 7,7,2,2},
            '{0,0,0,1, 0,0,0,  2,1,1, 15,1,3,3},
            '{0,0,0,1, 0,0,0,  1,1,1, 9,9,0,4},
            '{0,0,0,1, 0,0,0,  0,0,1, 0,0,0,0}
        };

        for (int i = 0; i < 18; i++) begin
            step(vt[i].rst[0], vt[i].flush[0], vt[i].iv[0], vt[i].ordy[0],
                 4'(vt[i].a), 4'(vt[i].b), 2'(vt[i].op), $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.count", i),  int'(count),      vt[i].e_cnt);
            chk($sformatf("vec%0d.valid", i),  int'(out_valid),  vt[i].e_valid);
            chk($sformatf("vec%0d.ready", i),  int'(in_ready),   vt[i].e_rdy);
            chk($sformatf("vec%0d.a", i),      int'(out_a),      vt[i].e_a);
            chk($sformatf("vec%0d.b", i),      int'(out_b),      vt[i].e_b);
            chk($sformatf("vec%0d.op", i),     int'(out_opcode), vt[i].e_op);
            chk($sformatf("vec%0d.seq", i),    int'(out_seq),    vt[i].e_seq);
        end

        // Three entries tagged 5..7, then flush with a concurrent push.
        step(0, 0, 1, 0, 4'h1, 4'h1, 2'd0, "fl_push");
        step(0, 0, 1, 0, 4'h2, 4'h2, 2'd1, "fl_push");
        step(0, 0, 1, 0, 4'h3, 4'h3, 2'd2, "fl_push");
        chk("fl.head_seq", int'(out_seq), 5);
        chk("fl.pre_count", int'(count), 3);
        step(0, 1, 1, 0, 4'hA, 4'hA, 2'd3, "flush");
        chk("fl.count", int'(count), 0);
        chk("fl.valid", int'(out_valid), 0);
        step(0, 0, 1, 0, 4'h4, 4'h4, 2'd3, "post_fl");
        chk("fl.next_seq", int'(out_seq), 8);

        // Reset mid-stream.
        step(0, 0, 1, 0, 4'h5, 4'h6, 2'd1, "pre_rst");
        step(1, 0, 1, 1, 4'h7, 4'h7, 2'd1, "rst_mid");
        chk("rst.count", int'(count), 0);
        step(0, 0, 1, 0, 4'h8, 4'h9, 2'd2, "post_rst");
        chk("rst.seq", int'(out_seq), 0);

        // Steady state at two entries with simultaneous push and pop; tags must wrap 255->0 without gaps.
        step(0, 0, 1, 0, 4'hB, 4'hC, 2'd3, "fill");
        last = int'(mq[0].seq);
        wrapped = 0;
        for (int i = 0; i < 300; i++) begin
            step(0, 0, 1, 1, 4'($urandom_range(15)), 4'($urandom_range(15)),
                 2'($urandom_range(3)), "steady");
            last = (last + 1) % 256;
            if (last == 0) wrapped = 1;
            chk("steady.count", int'(count), 2);
            chk("steady.seq", int'(out_seq), last);
        end
        chk("steady.wrapped", int'(wrapped), 1);

        // Random traffic against the reference queue.
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(199) == 0), 1'($urandom_range(49) == 0),
                 1'($urandom_range(1)), 1'($urandom_range(2) != 0),
                 4'($urandom_range(15)), 4'($urandom_range(15)),
                 2'($urandom_range(3)), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
